// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: one outstanding memory request at a time, responses buffered in a small FIFO.
// Response-to-InstrValid latency is one edge. New requests stall while every buffer slot is full or reserved.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic        MemReqValid,
    input  logic        MemReqReady,
    output logic [31:0] MemAddr,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] Instruction,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    input  logic        InstrReady
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_fetch_pc_nxt;
    logic [31:0]     w_redirect_pc;

    logic [31:0]     r_fifo_instr [DEPTH];
    logic [31:0]     r_fifo_pc    [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;

    logic            w_not_full;
    logic            w_req_fire;
    logic            w_push;
    logic            w_pop;

    assign w_redirect_pc = RedirectPC & ~32'h3;
    assign w_not_full    = (r_count < CW'(DEPTH));

    // Count is checked at request time, so an accepted request always owns a free slot.
    assign MemReqValid = !Reset && (r_state == ST_REQ) && w_not_full;
    assign MemAddr     = r_fetch_pc;
    assign w_req_fire  = MemReqValid && MemReqReady;

    assign InstrValid  = (r_count != '0);
    assign Instruction = InstrValid ? r_fifo_instr[r_rd_ptr] : 32'h0;
    assign InstrPC     = InstrValid ? r_fifo_pc[r_rd_ptr]    : 32'h0;
    assign w_pop       = InstrValid && InstrReady;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state    <= ST_REQ;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_push         = 1'b0;
        case (r_state)
            ST_REQ: begin
                if (w_req_fire) begin
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    w_state_nxt    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (MemRespValid) begin
                    w_push      = 1'b1;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (MemRespValid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            default: w_state_nxt = ST_REQ;
        endcase

        // A redirect drops buffered and arriving words; a request still owed a response must be drained.
        // A DRAIN whose response lands this cycle has nothing left to drain, so it returns to REQ.
        if (Redirect) begin
            w_push         = 1'b0;
            w_fetch_pc_nxt = w_redirect_pc;
            if (((r_state == ST_WAIT) && !MemRespValid) || w_req_fire) begin
                w_state_nxt = ST_DRAIN;
            end else if ((r_state == ST_DRAIN) && !MemRespValid) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_REQ;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_instr[i] <= 32'h0;
                r_fifo_pc[i]    <= 32'h0;
            end
        end else if (Redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= MemRespData;
                r_fifo_pc[r_wr_ptr]    <= r_fetch_pc - 32'd4;
                r_wr_ptr               <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
